// File: rtl/app_rx_buf.sv
// Store-and-forward receive buffer: stages app_* beats speculatively, commits whole datagrams, rewinds on cancel/overflow.
// Optional statistics counters (drop/ovf/frame) are built only when APP_RX_BUF_STATS_EN is defined.
module app_rx_buf #(
    parameter int DATA_W = 16,
    parameter int KEEP_W = DATA_W / 8,
    parameter int LEN_W  = $clog2(KEEP_W),
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              app_valid_i,
    input  logic              app_cancel_i,
    input  logic [DATA_W-1:0] app_data_i,
    input  logic [LEN_W-1:0]  app_len_i,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [LEN_W-1:0]  rd_len_o,
    output logic              rd_last_o
`ifdef APP_RX_BUF_STATS_EN
    ,
    output logic [CNT_W-1:0]  drop_cnt_o,
    output logic [CNT_W-1:0]  ovf_cnt_o,
    output logic [CNT_W-1:0]  frame_cnt_o
`endif
);

    localparam int E_W = 1 + LEN_W + DATA_W;
    localparam logic [PTR_W:0] DEPTH_P = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_SYNC,
        S_IDLE,
        S_RECV,
        S_DROP
    } state_t;

    state_t            state, state_nx;
    logic [PTR_W:0]    wr_ptr, cm_ptr, rd_ptr;
    logic [PTR_W:0]    wr_ptr_nx, cm_ptr_nx;
    logic [PTR_W:0]    occ;
    logic              full;
    logic [DATA_W-1:0] stage_data;
    logic [LEN_W-1:0]  stage_len;
    logic              stage_ld;
    logic              mem_we;
    logic              mem_last;
    logic              drop_ev, ovf_ev, frame_ev;
    logic [E_W-1:0]    mem [DEPTH];
    logic [E_W-1:0]    rd_entry;
    logic              rd_hs;

    assign occ  = wr_ptr - rd_ptr;
    assign full = (occ == DEPTH_P);

    always_ff @(posedge clk) begin
        if (nreset) begin
            state <= S_SYNC;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        stage_ld  = 1'b0;
        mem_we    = 1'b0;
        mem_last  = 1'b0;
        wr_ptr_nx = wr_ptr;
        cm_ptr_nx = cm_ptr;
        drop_ev   = 1'b0;
        ovf_ev    = 1'b0;
        frame_ev  = 1'b0;
        case (state)
            S_SYNC: begin
                if (!app_valid_i) begin
                    state_nx = S_IDLE;
                end
            end
            S_IDLE: begin
                if (app_valid_i) begin
                    if (app_cancel_i) begin
                        drop_ev  = 1'b1;
                        state_nx = S_DROP;
                    end else begin
                        stage_ld = 1'b1;
                        state_nx = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (app_valid_i) begin
                    // cancel outranks full so a cancelled frame is never counted as overflow
                    if (app_cancel_i) begin
                        wr_ptr_nx = cm_ptr;
                        drop_ev   = 1'b1;
                        state_nx  = S_DROP;
                    end else if (full) begin
                        wr_ptr_nx = cm_ptr;
                        ovf_ev    = 1'b1;
                        state_nx  = S_DROP;
                    end else begin
                        mem_we    = 1'b1;
                        wr_ptr_nx = wr_ptr + 1'b1;
                        stage_ld  = 1'b1;
                    end
                end else begin
                    state_nx = S_IDLE;
                    if (app_cancel_i) begin
                        wr_ptr_nx = cm_ptr;
                        drop_ev   = 1'b1;
                    end else if (full) begin
                        wr_ptr_nx = cm_ptr;
                        ovf_ev    = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        mem_last  = 1'b1;
                        wr_ptr_nx = wr_ptr + 1'b1;
                        cm_ptr_nx = wr_ptr + 1'b1;
                        frame_ev  = 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (!app_valid_i) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            stage_data <= '0;
            stage_len  <= '0;
        end else if (stage_ld) begin
            stage_data <= app_data_i;
            stage_len  <= app_len_i;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !nreset) begin
            mem[wr_ptr[PTR_W-1:0]] <= {mem_last, stage_len, stage_data};
        end
    end

    assign rd_hs = rd_valid_o & rd_ready_i;

    always_ff @(posedge clk) begin
        if (nreset) begin
            wr_ptr <= '0;
            cm_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_nx;
            cm_ptr <= cm_ptr_nx;
            if (rd_hs) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Show-ahead read; outputs are forced to zero while nothing committed is pending
    assign rd_entry   = mem[rd_ptr[PTR_W-1:0]];
    assign rd_valid_o = (rd_ptr != cm_ptr);
    assign rd_data_o  = rd_valid_o ? rd_entry[DATA_W-1:0] : '0;
    assign rd_len_o   = rd_valid_o ? rd_entry[DATA_W +: LEN_W] : '0;
    assign rd_last_o  = rd_valid_o ? rd_entry[E_W-1] : 1'b0;

`ifdef APP_RX_BUF_STATS_EN
    always_ff @(posedge clk) begin
        if (nreset) begin
            drop_cnt_o  <= '0;
            ovf_cnt_o   <= '0;
            frame_cnt_o <= '0;
        end else begin
            if (drop_ev && (drop_cnt_o != '1)) begin
                drop_cnt_o <= drop_cnt_o + 1'b1;
            end
            if (ovf_ev && (ovf_cnt_o != '1)) begin
                ovf_cnt_o <= ovf_cnt_o + 1'b1;
            end
            if (frame_ev && (frame_cnt_o != '1)) begin
                frame_cnt_o <= frame_cnt_o + 1'b1;
            end
        end
    end
`else
    logic unused_ev;
    assign unused_ev = drop_ev ^ ovf_ev ^ frame_ev;
`endif

endmodule

// File: tb/tb_app_rx_buf.sv
// Self-checking bench for app_rx_buf: directed scenarios plus randomized frames against a queue-based datagram model.
module tb_app_rx_buf;

    localparam int DATA_W = 16;
    localparam int LEN_W  = 1;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 16;
    localparam int E_W    = 1 + LEN_W + DATA_W;

    logic              clk = 1'b0;
    logic              nreset = 1'b1;
    logic              app_valid_i = 1'b0;
    logic              app_cancel_i = 1'b0;
    logic [DATA_W-1:0] app_data_i = '0;
    logic [LEN_W-1:0]  app_len_i = '0;
    logic              rd_valid_o;
    logic              rd_ready_i = 1'b0;
    logic [DATA_W-1:0] rd_data_o;
    logic [LEN_W-1:0]  rd_len_o;
    logic              rd_last_o;
`ifdef APP_RX_BUF_STATS_EN
    logic [CNT_W-1:0]  drop_cnt_o, ovf_cnt_o, frame_cnt_o;
`endif

    always #5 clk = ~clk;

    app_rx_buf #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .app_valid_i (app_valid_i),
        .app_cancel_i(app_cancel_i),
        .app_data_i  (app_data_i),
        .app_len_i   (app_len_i),
        .rd_valid_o  (rd_valid_o),
        .rd_ready_i  (rd_ready_i),
        .rd_data_o   (rd_data_o),
        .rd_len_o    (rd_len_o),
        .rd_last_o   (rd_last_o)
`ifdef APP_RX_BUF_STATS_EN
        ,
        .drop_cnt_o  (drop_cnt_o),
        .ovf_cnt_o   (ovf_cnt_o),
        .frame_cnt_o (frame_cnt_o)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: committed-but-unread beats as {last, len, data}, plus datagram counters
    logic [E_W-1:0]          exp_q[$];
    logic [LEN_W+DATA_W-1:0] tx_q[$];
    int exp_drop, exp_ovf, exp_frame;
    bit wr_done;

    task automatic apply_reset();
        nreset = 1'b1;
        app_valid_i = 1'b0; app_cancel_i = 1'b0; app_data_i = '0; app_len_i = '0;
        rd_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nreset = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        tx_q.delete();
        exp_drop = 0; exp_ovf = 0; exp_frame = 0;
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) begin
            tx_q.push_back({LEN_W'($urandom), DATA_W'($urandom)});
        end
    endtask

    // Drives tx_q as one datagram followed by its close cycle and updates the model.
    // A cancelled frame never overflows first because callers keep it within free space.
    task automatic send_frame(input int cancel_beat, input bit cancel_close, input bit chk_lat, input string name);
        int n, free_sp;
        bit cxl;
        n = tx_q.size();
        free_sp = DEPTH - exp_q.size();
        cxl = (cancel_beat >= 0) || cancel_close;
        for (int i = 0; i < n; i++) begin
            app_valid_i  = 1'b1;
            app_cancel_i = (i == cancel_beat);
            {app_len_i, app_data_i} = tx_q[i];
            @(posedge clk); #1;
        end
        app_valid_i = 1'b0; app_cancel_i = cancel_close; app_data_i = '0; app_len_i = '0;
        if (cxl) exp_drop++;
        else if (n > free_sp) exp_ovf++;
        else begin
            for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), tx_q[i]});
            exp_frame++;
        end
        if (chk_lat) begin
            n_checks++;
            if (rd_valid_o !== 1'b0) $display("FAIL %s_close_valid: got %b expected 0", name, rd_valid_o);
            else n_pass++;
        end
        @(posedge clk); #1;
        app_cancel_i = 1'b0;
        if (chk_lat) begin
            n_checks++;
            if (rd_valid_o !== 1'b1) $display("FAIL %s_commit_latency: got %b expected 1", name, rd_valid_o);
            else n_pass++;
        end
        tx_q.delete();
    endtask

    // Reads until the model is empty (and the writer has finished when wait_wr), with random stalls.
    task automatic drain(input string name, input int stall_pct, input bit wait_wr);
        int cyc;
        bit have_prev, rdy;
        logic [E_W-1:0] prev, cur;
        cyc = 0; have_prev = 1'b0; prev = '0;
        while ((exp_q.size() > 0 || (wait_wr && !wr_done)) && cyc < 4000) begin
            cyc++;
            cur = {rd_last_o, rd_len_o, rd_data_o};
            if (have_prev) begin
                n_checks++;
                if (rd_valid_o !== 1'b1 || cur !== prev)
                    $display("FAIL %s_stall_hold: got v=%b %h expected v=1 %h", name, rd_valid_o, cur, prev);
                else n_pass++;
            end
            rdy = ($urandom_range(99) >= stall_pct);
            rd_ready_i = rdy;
            have_prev = rd_valid_o && !rdy;
            prev = cur;
            if (rd_valid_o && rdy) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL %s_extra_beat: got %h expected no beat", name, cur);
                else begin
                    if (cur !== exp_q[0]) $display("FAIL %s_beat: got %h expected %h", name, cur, exp_q[0]);
                    else n_pass++;
                    void'(exp_q.pop_front());
                end
            end
            @(posedge clk); #1;
        end
        rd_ready_i = 1'b0;
        n_checks++;
        if (exp_q.size() != 0 || (wait_wr && !wr_done))
            $display("FAIL %s_timeout: got %0d beats pending expected 0", name, exp_q.size());
        else n_pass++;
        n_checks++;
        if (rd_valid_o !== 1'b0) $display("FAIL %s_empty_after: got %b expected 0", name, rd_valid_o);
        else n_pass++;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({rd_valid_o, rd_last_o, rd_len_o, rd_data_o} !== '0)
            $display("FAIL reset_outputs: got %h expected 0", {rd_valid_o, rd_last_o, rd_len_o, rd_data_o});
        else n_pass++;
`ifdef APP_RX_BUF_STATS_EN
        n_checks++;
        if ({drop_cnt_o, ovf_cnt_o, frame_cnt_o} !== '0)
            $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", drop_cnt_o, ovf_cnt_o, frame_cnt_o);
        else n_pass++;
`endif
    endtask

    task automatic test_basic();
        apply_reset();
        tx_q.push_back({1'b0, 16'h01AA});
        tx_q.push_back({1'b0, 16'h02BB});
        tx_q.push_back({1'b1, 16'h03CC});
        send_frame(-1, 1'b0, 1'b1, "basic");
`ifdef APP_RX_BUF_STATS_EN
        n_checks++;
        if (frame_cnt_o !== CNT_W'(1)) $display("FAIL basic_frame_cnt: got %0d expected 1", frame_cnt_o);
        else n_pass++;
`endif
        drain("basic", 0, 1'b0);
    endtask

    task automatic test_cancel_close();
        apply_reset();
        fill_rand(2);
        send_frame(-1, 1'b1, 1'b0, "cxl_close");
        repeat (3) begin
            n_checks++;
            if (rd_valid_o !== 1'b0) $display("FAIL cxl_close_valid: got %b expected 0", rd_valid_o);
            else n_pass++;
            @(posedge clk); #1;
        end
`ifdef APP_RX_BUF_STATS_EN
        n_checks++;
        if ({drop_cnt_o, frame_cnt_o} !== {CNT_W'(exp_drop), CNT_W'(exp_frame)})
            $display("FAIL cxl_close_cnt: got drop=%0d frame=%0d expected %0d/%0d", drop_cnt_o, frame_cnt_o, exp_drop, exp_frame);
        else n_pass++;
`endif
    endtask

    task automatic test_overflow();
        apply_reset();
        fill_rand(20);
        send_frame(-1, 1'b0, 1'b0, "ovf");
        @(posedge clk); #1;
        n_checks++;
        if (rd_valid_o !== 1'b0) $display("FAIL ovf_readable: got %b expected 0", rd_valid_o);
        else n_pass++;
`ifdef APP_RX_BUF_STATS_EN
        n_checks++;
        if (ovf_cnt_o !== CNT_W'(1)) $display("FAIL ovf_cnt: got %0d expected 1", ovf_cnt_o);
        else n_pass++;
`endif
        fill_rand(2);
        send_frame(-1, 1'b0, 1'b0, "ovf_next");
        drain("ovf_next", 0, 1'b0);
    endtask

    task automatic test_boundary();
        apply_reset();
        fill_rand(DEPTH);
        send_frame(-1, 1'b0, 1'b0, "bnd_full");
        fill_rand(1);
        send_frame(-1, 1'b0, 1'b0, "bnd_over");
`ifdef APP_RX_BUF_STATS_EN
        n_checks++;
        if ({ovf_cnt_o, frame_cnt_o} !== {CNT_W'(1), CNT_W'(1)})
            $display("FAIL bnd_cnt: got ovf=%0d frame=%0d expected 1/1", ovf_cnt_o, frame_cnt_o);
        else n_pass++;
`endif
        drain("bnd", 20, 1'b0);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        fill_rand(3);
        send_frame(-1, 1'b0, 1'b0, "b2b_a");
        fill_rand(3);
        send_frame(-1, 1'b0, 1'b0, "b2b_b");
        repeat (4) begin
            n_checks++;
            if (rd_valid_o !== 1'b1 || {rd_last_o, rd_len_o, rd_data_o} !== exp_q[0])
                $display("FAIL b2b_stalled: got v=%b %h expected v=1 %h", rd_valid_o, {rd_last_o, rd_len_o, rd_data_o}, exp_q[0]);
            else n_pass++;
            @(posedge clk); #1;
        end
        drain("b2b", 0, 1'b0);
    endtask

    task automatic test_reset_midframe();
        apply_reset();
        fill_rand(2);
        send_frame(-1, 1'b0, 1'b0, "rst_a");
        app_valid_i = 1'b1;
        repeat (2) begin
            app_data_i = DATA_W'($urandom);
            @(posedge clk); #1;
        end
        nreset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b0;
        exp_q.delete();
        exp_drop = 0; exp_ovf = 0; exp_frame = 0;
        repeat (3) begin
            app_data_i = DATA_W'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if (rd_valid_o !== 1'b0) $display("FAIL rst_tail_valid: got %b expected 0", rd_valid_o);
            else n_pass++;
        end
        app_valid_i = 1'b0; app_data_i = '0;
        @(posedge clk); #1;
        n_checks++;
        if (rd_valid_o !== 1'b0) $display("FAIL rst_after_tail: got %b expected 0", rd_valid_o);
        else n_pass++;
`ifdef APP_RX_BUF_STATS_EN
        n_checks++;
        if ({drop_cnt_o, ovf_cnt_o, frame_cnt_o} !== '0)
            $display("FAIL rst_counters: got %0d/%0d/%0d expected 0/0/0", drop_cnt_o, ovf_cnt_o, frame_cnt_o);
        else n_pass++;
`endif
        fill_rand(1);
        send_frame(-1, 1'b0, 1'b0, "rst_b");
        drain("rst_b", 0, 1'b0);
    endtask

    task automatic test_cancel_mid();
        apply_reset();
        fill_rand(3);
        send_frame(-1, 1'b0, 1'b0, "cxl_mid_a");
        fill_rand(4);
        send_frame(1, 1'b0, 1'b0, "cxl_mid_b");
`ifdef APP_RX_BUF_STATS_EN
        n_checks++;
        if ({drop_cnt_o, frame_cnt_o} !== {CNT_W'(1), CNT_W'(1)})
            $display("FAIL cxl_mid_cnt: got drop=%0d frame=%0d expected 1/1", drop_cnt_o, frame_cnt_o);
        else n_pass++;
`endif
        drain("cxl_mid", 30, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            apply_reset();
            for (int f = 0; f < 6; f++) begin
                int n, free_sp, pos;
                free_sp = DEPTH - exp_q.size();
                if ($urandom_range(3) == 0) begin
                    n = 1 + $urandom_range(((free_sp > 1) ? free_sp : 1) - 1);
                    pos = $urandom_range(n);
                    fill_rand(n);
                    if (pos == n) send_frame(-1, 1'b1, 1'b0, "rnd");
                    else send_frame(pos, 1'b0, 1'b0, "rnd");
                end else begin
                    n = 1 + $urandom_range(DEPTH + 3);
                    fill_rand(n);
                    send_frame(-1, 1'b0, 1'b0, "rnd");
                end
            end
`ifdef APP_RX_BUF_STATS_EN
            n_checks++;
            if ({drop_cnt_o, ovf_cnt_o, frame_cnt_o} !== {CNT_W'(exp_drop), CNT_W'(exp_ovf), CNT_W'(exp_frame)})
                $display("FAIL rnd_cnt: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         drop_cnt_o, ovf_cnt_o, frame_cnt_o, exp_drop, exp_ovf, exp_frame);
            else n_pass++;
`endif
            drain("rnd", 50, 1'b0);
        end
    endtask

    task automatic test_concurrent();
        apply_reset();
        wr_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 16; f++) begin
                    int n, waitc;
                    n = 1 + $urandom_range(3);
                    waitc = 0;
                    while (exp_q.size() + n + 1 > DEPTH && waitc < 500) begin
                        @(posedge clk); #1;
                        waitc++;
                    end
                    fill_rand(n);
                    if ($urandom_range(4) == 0) send_frame($urandom_range(n - 1), 1'b0, 1'b0, "conc");
                    else send_frame(-1, 1'b0, 1'b0, "conc");
                end
                wr_done = 1'b1;
            end
            drain("conc", 30, 1'b1);
        join
`ifdef APP_RX_BUF_STATS_EN
        n_checks++;
        if ({drop_cnt_o, ovf_cnt_o, frame_cnt_o} !== {CNT_W'(exp_drop), CNT_W'(exp_ovf), CNT_W'(exp_frame)})
            $display("FAIL conc_cnt: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     drop_cnt_o, ovf_cnt_o, frame_cnt_o, exp_drop, exp_ovf, exp_frame);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cancel_close();
        test_overflow();
        test_boundary();
        test_back_to_back();
        test_reset_midframe();
        test_cancel_mid();
        test_random();
        test_concurrent();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
